uart_cmd_sched: RTL and testbench
=================================

Name: uart_cmd_sched

Overview:
- Sequencing controller between the UART RX/TX FIFOs and the stopwatch/watch core.
- Pops command bytes from the RX FIFO and issues one-cycle control pulses plus mode/digit toggles.
- Optionally echoes each byte and, on request, streams a time report "HH:MM:SS\r\n" into the TX FIFO.
- Sole owner of the RX pop and TX push strobes; one command is processed at a time.

Parameters:
ECHO_EN, 1, 1 = echo every received byte to TX before any report
REPORT_CHAR, 8'h72, command byte ('r') that triggers the time report

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_empty  input  1  RX FIFO empty flag
rx_data  input  8  RX FIFO head byte (first-word-fall-through, valid while !rx_empty)
o_rx_pop  output  1  RX FIFO pop strobe
tx_full  input  1  TX FIFO full flag
o_tx_push  output  1  TX FIFO push strobe
o_tx_data  output  8  byte written when o_tx_push=1
i_hour  input  5  current hour, binary
i_min  input  6  current minute, binary
i_sec  input  6  current second, binary
o_start  output  1  pulse on 's' (8'h73)
o_stop  output  1  pulse on 't' (8'h74)
o_clear  output  1  pulse on 'c' (8'h63)
o_hour_p  output  1  pulse on 'H' (8'h48)
o_min_p  output  1  pulse on 'M' (8'h4D)
o_sec_p  output  1  pulse on 'S' (8'h53)
o_sel_m  output  1  mode level, toggled by 'm' (8'h6D)
o_sel_a  output  1  digit-select level, toggled by 'a' (8'h61)
o_busy  output  1  1 whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; r_cmd=0; index=0; o_sel_m=0; o_sel_a=0. All pulses, o_rx_pop and o_tx_push are 0. o_tx_data=0.
- FSM states: IDLE, DECODE, ECHO, REPORT.
- IDLE:
  - o_rx_pop = !rx_empty, combinational.
  - On the pop cycle: r_cmd <= rx_data, next state DECODE.
- DECODE (exactly one cycle):
  - The matching command pulse is high for this cycle only.
  - 'm'/'a' toggle o_sel_m/o_sel_a at the end of this cycle.
  - If r_cmd==REPORT_CHAR: snapshot i_hour/i_min/i_sec into registers this cycle.
  - Next state: ECHO if ECHO_EN; else REPORT if r_cmd==REPORT_CHAR; else IDLE.
- ECHO:
  - o_tx_data=r_cmd; o_tx_push = !tx_full.
  - Hold while tx_full.
  - After the push: REPORT if r_cmd==REPORT_CHAR, else IDLE.
- REPORT:
  - index counts 0..9 over bytes: Ht, Ho, ':', Mt, Mo, ':', St, So, 8'h0D, 8'h0A.
  - o_tx_push = !tx_full; index advances only on a push.
  - After index 9 is pushed: index=0, go to IDLE.
- Digit conversion:
  - tens = v/10, ones = v%10, ASCII = 8'h30 + digit.
  - Covers 0..63, e.g. 63 -> "63".
  - Out-of-clock-range values are reported as-is, not saturated.
- Time snapshot: taken once per report, so the digits are consistent even if the time rolls over mid-report.
- Unknown bytes (including 8'h00): no pulse and no toggle; echoed if ECHO_EN.
- Latency:
  - Pulse appears 1 cycle after the pop cycle.
  - First echo push 2 cycles after the pop if TX is not full.
- Throughput:
  - Minimum 2 cycles per command (ECHO_EN=0, non-report).
  - Minimum 3 cycles with echo.
- Flow control:
  - No RX pop occurs while state != IDLE; the RX FIFO absorbs the backlog.
  - No push occurs when tx_full=1. tx_full may toggle arbitrarily.
- o_busy = (state != IDLE).
- Reset mid-report or mid-echo:
  - Abort immediately to IDLE with no further pushes.
  - A partial report is not resumed.
  - Bytes already pushed remain in the TX FIFO.
- All outputs are glitch-free decodes of registered state/r_cmd; there is no path from rx_data to the pulse outputs.

Decomposition:
- Shared package holds:
  - command byte constants (CMD_START 8'h73, CMD_STOP 8'h74, CMD_CLEAR 8'h63, CMD_HOUR 8'h48, CMD_MIN 8'h4D, CMD_SEC 8'h53, CMD_MODE 8'h6D, CMD_DIGIT 8'h61, CMD_REPORT 8'h72);
  - ASCII constants (':' 8'h3A, CR 8'h0D, LF 8'h0A, '0' 8'h30);
  - the FSM state encoding.
- One sub-module: bin2ascii_2d, a combinational 6-bit binary to two-ASCII-digit converter. It is instantiated three times, for hour, minute and second.

Test Plan:
- Reset and single command:
  - Stimulus: reset, then RX holds 's'.
  - Required: o_rx_pop 1 cycle, o_start high exactly 1 cycle one cycle later. With ECHO_EN=1, o_tx_push with o_tx_data=8'h73 once.
- Toggles:
  - Stimulus: RX holds "m","m","a".
  - Required: o_sel_m goes 0->1->0 and o_sel_a=1. No pulse outputs asserted.
- Report:
  - Stimulus: i_hour=9, i_min=5, i_sec=59, RX holds 'r', ECHO_EN=1.
  - Required: TX bytes 72 30 39 3A 30 35 3A 35 39 0D 0A in order.
- Backpressure:
  - Stimulus: during the report, tx_full=1 for 5 cycles at index 4.
  - Required: no push while full, the byte is not lost, the sequence completes identically, and o_busy stays 1.
- Snapshot:
  - Stimulus: i_sec changes 59->0 mid-report.
  - Required: the report still reads "59" seconds.
- Reset abort, then unknown byte:
  - Stimulus: assert rst at index 3, then send 'x'.
  - Required: no push after rst and state=IDLE. For 'x': echo only, no pulse.

Source files
------------

// File: rtl/uart_cmd_sched_pkg.sv
// uart_cmd_sched_pkg: command bytes, ASCII constants and FSM encoding for the UART command scheduler
package uart_cmd_sched_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, ECHO, REPORT} state_t;
  localparam logic [7:0] CMD_START  = 8'h73;
  localparam logic [7:0] CMD_STOP   = 8'h74;
  localparam logic [7:0] CMD_CLEAR  = 8'h63;
  localparam logic [7:0] CMD_HOUR   = 8'h48;
  localparam logic [7:0] CMD_MIN    = 8'h4D;
  localparam logic [7:0] CMD_SEC    = 8'h53;
  localparam logic [7:0] CMD_MODE   = 8'h6D;
  localparam logic [7:0] CMD_DIGIT  = 8'h61;
  localparam logic [7:0] CMD_REPORT = 8'h72;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
endpackage

// File: rtl/uart_cmd_sched_if.sv
// uart_cmd_sched_if: RX/TX FIFO handshake between the scheduler (master) and the FIFOs (slave)
interface uart_cmd_sched_if;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       o_rx_pop;
  logic       tx_full;
  logic       o_tx_push;
  logic [7:0] o_tx_data;
  modport master (input rx_empty, rx_data, tx_full, output o_rx_pop, o_tx_push, o_tx_data);
  modport slave (output rx_empty, rx_data, tx_full, input o_rx_pop, o_tx_push, o_tx_data);
endinterface

// File: rtl/uart_cmd_sched_bin2ascii_2d.sv
// bin2ascii_2d: 6-bit binary to two ASCII decimal digits, unsaturated over 0..63
module bin2ascii_2d
  import uart_cmd_sched_pkg::*;
(
  input  logic [5:0] bin,
  output logic [7:0] tens,
  output logic [7:0] ones
);
  assign tens = ASCII_ZERO + 8'(bin / 6'd10);
  assign ones = ASCII_ZERO + 8'(bin % 6'd10);
endmodule

// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: pops RX command bytes, pulses/toggles core controls, echoes and streams HH:MM:SS reports to TX
module uart_cmd_sched
  import uart_cmd_sched_pkg::*;
#(
  parameter bit         ECHO_EN     = 1'b1,
  parameter logic [7:0] REPORT_CHAR = CMD_REPORT
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_cmd_sched_if.master         fifo,
  input  logic [4:0]               i_hour,
  input  logic [5:0]               i_min,
  input  logic [5:0]               i_sec,
  output logic                     o_start,
  output logic                     o_stop,
  output logic                     o_clear,
  output logic                     o_hour_p,
  output logic                     o_min_p,
  output logic                     o_sec_p,
  output logic                     o_sel_m,
  output logic                     o_sel_a,
  output logic                     o_busy
);
  state_t       state_q, state_d;
  logic [7:0]   r_cmd_q, r_cmd_d;
  logic [3:0]   idx_q, idx_d;
  logic         sel_m_q, sel_m_d, sel_a_q, sel_a_d;
  logic [4:0]   hour_q, hour_d;
  logic [5:0]   min_q, min_d, sec_q, sec_d;
  logic [7:0]   ht, ho, mt, mo, st, so;
  logic [9:0][7:0] rpt;
  logic         pop, push, dec, is_rpt;
  bin2ascii_2d u_hour (.bin({1'b0, hour_q}), .tens(ht), .ones(ho));
  bin2ascii_2d u_min  (.bin(min_q),          .tens(mt), .ones(mo));
  bin2ascii_2d u_sec  (.bin(sec_q),          .tens(st), .ones(so));
  assign rpt = {ASCII_LF, ASCII_CR, so, st, ASCII_COLON, mo, mt, ASCII_COLON, ho, ht};
  assign is_rpt = r_cmd_q == REPORT_CHAR;
  assign dec    = state_q == DECODE;
  assign pop    = !rst && state_q == IDLE && !fifo.rx_empty;
  assign push   = !rst && (state_q == ECHO || state_q == REPORT) && !fifo.tx_full;
  assign fifo.o_rx_pop  = pop;
  assign fifo.o_tx_push = push;
  assign fifo.o_tx_data = state_q == ECHO ? r_cmd_q : state_q == REPORT ? rpt[idx_q] : 8'h00;
  assign o_start  = dec && r_cmd_q == CMD_START;
  assign o_stop   = dec && r_cmd_q == CMD_STOP;
  assign o_clear  = dec && r_cmd_q == CMD_CLEAR;
  assign o_hour_p = dec && r_cmd_q == CMD_HOUR;
  assign o_min_p  = dec && r_cmd_q == CMD_MIN;
  assign o_sec_p  = dec && r_cmd_q == CMD_SEC;
  assign o_sel_m  = sel_m_q;
  assign o_sel_a  = sel_a_q;
  assign o_busy   = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    r_cmd_d = r_cmd_q;
    idx_d   = idx_q;
    sel_m_d = sel_m_q;
    sel_a_d = sel_a_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    case (state_q)
      IDLE: if (pop) begin
        r_cmd_d = fifo.rx_data;
        state_d = DECODE;
      end
      DECODE: begin
        sel_m_d = sel_m_q ^ (r_cmd_q == CMD_MODE);
        sel_a_d = sel_a_q ^ (r_cmd_q == CMD_DIGIT);
        hour_d  = is_rpt ? i_hour : hour_q;
        min_d   = is_rpt ? i_min : min_q;
        sec_d   = is_rpt ? i_sec : sec_q;
        state_d = ECHO_EN ? ECHO : is_rpt ? REPORT : IDLE;
      end
      ECHO: if (push) state_d = is_rpt ? REPORT : IDLE;
      REPORT: if (push) begin
        idx_d   = idx_q == 4'd9 ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q == 4'd9 ? IDLE : REPORT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_cmd_q <= '0;
      idx_q   <= '0;
      sel_m_q <= 1'b0;
      sel_a_q <= 1'b0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      r_cmd_q <= r_cmd_d;
      idx_q   <= idx_d;
      sel_m_q <= sel_m_d;
      sel_a_q <= sel_a_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end
endmodule

// File: tb/tb_uart_cmd_sched.sv
// tb_uart_cmd_sched: directed and randomized checks of uart_cmd_sched against a byte-stream reference model
module tb_uart_cmd_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] i_hour = '0;
  logic [5:0] i_min = '0;
  logic [5:0] i_sec = '0;
  logic       o_start, o_stop, o_clear, o_hour_p, o_min_p, o_sec_p, o_sel_m, o_sel_a, o_busy;
  uart_cmd_sched_if bus ();
  uart_cmd_sched dut (
    .clk(clk), .rst(rst), .fifo(bus.master),
    .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec),
    .o_start(o_start), .o_stop(o_stop), .o_clear(o_clear),
    .o_hour_p(o_hour_p), .o_min_p(o_min_p), .o_sec_p(o_sec_p),
    .o_sel_m(o_sel_m), .o_sel_a(o_sel_a), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic       pop_seen = 1'b0;
  logic       rand_full = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] tx_got[$];
  logic [7:0] pulse_got[$];
  int         pop_cyc[$];
  int         pulse_cyc[$];
  int         push_cyc[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_pulse[$];
  logic       exp_m = 1'b0;
  logic       exp_a = 1'b0;
  logic [7:0] cmds [11] = '{8'h73, 8'h74, 8'h63, 8'h48, 8'h4D, 8'h53, 8'h6D, 8'h61, 8'h72, 8'h78, 8'h00};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    int np;
    cyc++;
    pop_seen = bus.o_rx_pop;
    if (bus.o_rx_pop) pop_cyc.push_back(cyc);
    if (bus.tx_full) chk("push_while_full", 32'(bus.o_tx_push), 0);
    if (bus.o_tx_push) begin
      tx_got.push_back(bus.o_tx_data);
      push_cyc.push_back(cyc);
    end
    np = int'(o_start) + int'(o_stop) + int'(o_clear) + int'(o_hour_p) + int'(o_min_p) + int'(o_sec_p);
    if (np != 0) begin
      pulse_got.push_back(np > 1 ? 8'hFF : o_start ? 8'h73 : o_stop ? 8'h74 : o_clear ? 8'h63 :
                          o_hour_p ? 8'h48 : o_min_p ? 8'h4D : 8'h53);
      pulse_cyc.push_back(cyc);
    end
  end
  always @(posedge clk) begin
    #1;
    if (pop_seen && rxq.size() > 0) void'(rxq.pop_front());
    bus.rx_empty = rxq.size() == 0;
    bus.rx_data  = rxq.size() == 0 ? 8'h00 : rxq[0];
  end
  always @(posedge clk) begin
    #3;
    if (rand_full) bus.tx_full = $urandom_range(0, 2) == 0;
  end
  function automatic void model(input logic [7:0] c, input int h, input int m, input int s);
    exp_tx.push_back(c);
    if (c == 8'h72)
      exp_tx = {exp_tx, 8'(48 + h / 10), 8'(48 + h % 10), 8'h3A, 8'(48 + m / 10), 8'(48 + m % 10),
                8'h3A, 8'(48 + s / 10), 8'(48 + s % 10), 8'h0D, 8'h0A};
    if (c inside {8'h73, 8'h74, 8'h63, 8'h48, 8'h4D, 8'h53}) exp_pulse.push_back(c);
    if (c == 8'h6D) exp_m = !exp_m;
    if (c == 8'h61) exp_a = !exp_a;
  endfunction
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_idle();
    int i;
    repeat (3) step();
    for (i = 0; i < 800 && !(rxq.size() == 0 && bus.rx_empty && !o_busy); i++) step();
    chk("idle_timeout", 32'(i < 800), 1);
  endtask
  task automatic compare(input string tag);
    chk({tag, "_tx_len"}, tx_got.size(), exp_tx.size());
    for (int i = 0; i < tx_got.size() && i < exp_tx.size(); i++) chk({tag, "_tx_byte"}, tx_got[i], exp_tx[i]);
    chk({tag, "_pulse_len"}, pulse_got.size(), exp_pulse.size());
    for (int i = 0; i < pulse_got.size() && i < exp_pulse.size(); i++) chk({tag, "_pulse"}, pulse_got[i], exp_pulse[i]);
    chk({tag, "_sel_m"}, 32'(o_sel_m), 32'(exp_m));
    chk({tag, "_sel_a"}, 32'(o_sel_a), 32'(exp_a));
    tx_got.delete(); exp_tx.delete(); pulse_got.delete(); exp_pulse.delete();
    pop_cyc.delete(); pulse_cyc.delete(); push_cyc.delete();
  endtask
  initial begin
    int n, h, m, s;
    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'h00;
    bus.tx_full  = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_push", 32'(bus.o_tx_push), 0);
    chk("rst_txdata", 32'(bus.o_tx_data), 0);
    chk("rst_pop", 32'(bus.o_rx_pop), 0);
    chk("rst_pulses", {o_start, o_stop, o_clear, o_hour_p, o_min_p, o_sec_p, o_sel_m, o_sel_a}, 0);
    rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(o_busy), 0);
    tx_got.delete(); pulse_got.delete(); pop_cyc.delete(); pulse_cyc.delete(); push_cyc.delete();
    model(8'h73, 0, 0, 0);
    rxq.push_back(8'h73);
    wait_idle();
    chk("s_pop_count", pop_cyc.size(), 1);
    chk("s_pulse_lat", (pop_cyc.size() > 0 && pulse_cyc.size() > 0) ? pulse_cyc[0] - pop_cyc[0] : -1, 1);
    chk("s_echo_lat", (pop_cyc.size() > 0 && push_cyc.size() > 0) ? push_cyc[0] - pop_cyc[0] : -1, 2);
    compare("start");
    model(8'h6D, 0, 0, 0);
    rxq.push_back(8'h6D);
    wait_idle();
    chk("m_first_toggle", 32'(o_sel_m), 1);
    model(8'h6D, 0, 0, 0);
    model(8'h61, 0, 0, 0);
    rxq.push_back(8'h6D);
    rxq.push_back(8'h61);
    wait_idle();
    compare("toggle");
    i_hour = 5'd9; i_min = 6'd5; i_sec = 6'd59;
    model(8'h72, 9, 5, 59);
    rxq.push_back(8'h72);
    n = 0;
    while (tx_got.size() < 5 && n < 100) begin step(); n++; end
    chk("rpt_reach_idx4", 32'(tx_got.size()), 5);
    bus.tx_full = 1'b1;
    i_sec = 6'd0;
    repeat (5) begin
      step();
      chk("bp_busy", 32'(o_busy), 1);
    end
    chk("bp_no_push", 32'(tx_got.size()), 5);
    bus.tx_full = 1'b0;
    wait_idle();
    compare("report");
    i_hour = 5'd12; i_min = 6'd34; i_sec = 6'd56;
    rxq.push_back(8'h72);
    n = 0;
    while (tx_got.size() < 4 && n < 100) begin step(); n++; end
    chk("abort_reach_idx3", 32'(tx_got.size()), 4);
    rst = 1'b1;
    step();
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_push", 32'(bus.o_tx_push), 0);
    rst = 1'b0;
    repeat (5) step();
    chk("abort_no_more", 32'(tx_got.size()), 4);
    exp_m = 1'b0;
    exp_a = 1'b0;
    tx_got.delete(); pulse_got.delete();
    model(8'h78, 0, 0, 0);
    rxq.push_back(8'h78);
    wait_idle();
    compare("unknown");
    rand_full = 1'b1;
    for (int b = 0; b < 12; b++) begin
      h = int'($urandom_range(0, 31));
      m = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 63));
      i_hour = 5'(h); i_min = 6'(m); i_sec = 6'(s);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        logic [7:0] c;
        c = cmds[$urandom_range(0, 10)];
        model(c, h, m, s);
        rxq.push_back(c);
      end
      wait_idle();
      compare("random");
    end
    rand_full = 1'b0;
    bus.tx_full = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
